// File: rtl/temp_frame_tx.sv
// Multi-channel DS18B20 telemetry framer: latches per-channel readings and sends
// HEADER, N_CH, fresh bitmap, channel bytes (MSB first) and an 8-bit sum to the UART.
module temp_frame_tx #(
    parameter int         N_CH       = 3,
    parameter int         DATA_W     = 16,
    parameter logic [7:0] HEADER     = 8'hA5,
    parameter bit         AUTO       = 1'b1,
    parameter int         PERIOD_CYC = 27_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic                   start,
    input  logic                   tx_busy,
    output logic                   wr,
    output logic [7:0]             data_out,
    output logic                   frame_busy,
    output logic [7:0]             overrun_cnt
);

    localparam int LAST = 3 + 2*N_CH;
    localparam int IW   = $clog2(LAST + 1);
    localparam int TW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SNAP, ISSUE, ACK, HOLD, DONE} state_t;

    state_t                       state, state_nxt;
    logic [N_CH-1:0][DATA_W-1:0]  shadow, frm;
    logic [N_CH-1:0]              fresh, frm_fresh;
    logic [IW-1:0]                idx;
    logic [7:0]                   chk, cur_byte, last_byte;
    logic                         pending, tick, trig;

    generate
        if (AUTO) begin : g_timer
            logic [TW-1:0] tmr;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)                           tmr <= '0;
                else if (tmr == TW'(PERIOD_CYC-1))  tmr <= '0;
                else                                tmr <= tmr + 1'b1;
            end
            assign tick = (tmr == TW'(PERIOD_CYC-1));
        end else begin : g_no_timer
            assign tick = 1'b0;
        end
    endgenerate

    assign trig = start | tick;

    // A reading arriving in SNAP still lands in the shadow and marks it fresh for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            fresh  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++)
                if (ch_valid[k]) shadow[k] <= ch_data[k*DATA_W +: DATA_W];
            fresh <= ((state == SNAP) ? '0 : fresh) | ch_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm         <= '0;
            frm_fresh   <= '0;
            idx         <= '0;
            chk         <= '0;
            last_byte   <= '0;
            pending     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (state == SNAP) begin
                frm       <= shadow;
                frm_fresh <= fresh;
                idx       <= '0;
                chk       <= '0;
            end
            if (wr) begin
                last_byte <= cur_byte;
                if (idx != '0 && idx != IW'(LAST)) chk <= chk + cur_byte;
            end
            if (state == HOLD && !tx_busy && idx != IW'(LAST)) idx <= idx + 1'b1;
            // DONE consumes one queued request; a trigger arriving there stays queued.
            if (state == DONE)
                pending <= pending & trig;
            else if (state != IDLE && trig) begin
                if (!pending)                    pending     <= 1'b1;
                else if (overrun_cnt != 8'hFF)   overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cur_byte = chk;
        if (idx == '0)           cur_byte = HEADER;
        else if (idx == IW'(1))  cur_byte = 8'(N_CH);
        else if (idx == IW'(2))  cur_byte = 8'(frm_fresh);
        for (int k = 0; k < N_CH; k++) begin
            if (idx == IW'(3 + 2*k)) cur_byte = frm[k][15:8];
            if (idx == IW'(4 + 2*k)) cur_byte = frm[k][7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = SNAP;
            SNAP:    state_nxt = ISSUE;
            ISSUE:   if (!tx_busy) state_nxt = ACK;
            ACK:     state_nxt = HOLD;
            HOLD:    if (!tx_busy) state_nxt = (idx == IW'(LAST)) ? DONE : ISSUE;
            DONE:    state_nxt = (pending | trig) ? SNAP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wr and the byte are combinational so the UART sees them in the ISSUE cycle itself.
    assign wr         = (state == ISSUE) && !tx_busy;
    assign data_out   = wr ? cur_byte : last_byte;
    assign frame_busy = (state == SNAP) || (state == ISSUE) || (state == ACK) || (state == HOLD);

endmodule

// File: tb/tb_temp_frame_tx.sv
// Bench for temp_frame_tx: a manual-trigger instance checked byte-for-byte through a
// scoreboard, and an auto-timer instance checked for mid-frame reset and restart timing.
module tb_temp_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0, n_bad = 0;

    // ---------------- instance 0: AUTO=0 ----------------
    logic        rst0, start0, tx_busy0, wr0, frame_busy0;
    logic [47:0] ch_data0;
    logic [2:0]  ch_valid0;
    logic [7:0]  data_out0, overrun0;

    temp_frame_tx #(.N_CH(3), .DATA_W(16), .HEADER(8'hA5), .AUTO(1'b0), .PERIOD_CYC(1000)) dut0 (
        .clk(clk), .rst(rst0), .ch_data(ch_data0), .ch_valid(ch_valid0), .start(start0),
        .tx_busy(tx_busy0), .wr(wr0), .data_out(data_out0), .frame_busy(frame_busy0),
        .overrun_cnt(overrun0));

    // ---------------- instance 1: AUTO=1 ----------------
    logic        rst1, tx_busy1, wr1, frame_busy1;
    logic [47:0] ch_data1  = '0;
    logic [2:0]  ch_valid1 = '0;
    logic        start1    = 1'b0;
    logic [7:0]  data_out1, overrun1;

    temp_frame_tx #(.N_CH(3), .DATA_W(16), .HEADER(8'hA5), .AUTO(1'b1), .PERIOD_CYC(1000)) dut1 (
        .clk(clk), .rst(rst1), .ch_data(ch_data1), .ch_valid(ch_valid1), .start(start1),
        .tx_busy(tx_busy1), .wr(wr1), .data_out(data_out1), .frame_busy(frame_busy1),
        .overrun_cnt(overrun1));

    // UART models: busy rises one cycle after the wr cycle and lasts a fixed time.
    int   bcnt0 = 0, bcnt1 = 0;
    logic wrq0 = 1'b0, wrq1 = 1'b0, hold0 = 1'b0;
    always @(posedge clk) begin
        if (wrq0) bcnt0 <= 10; else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
        if (wrq1) bcnt1 <= 60; else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
        wrq0 <= wr0;
        wrq1 <= wr1;
    end
    assign tx_busy0 = (bcnt0 != 0) | hold0;
    assign tx_busy1 = (bcnt1 != 0);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard and model ----------------
    logic [7:0]  q[$];
    logic [15:0] m_sh[3];
    logic [2:0]  m_fr;
    int          wr_cnt0 = 0;

    always @(negedge clk) begin
        if (wr0) begin
            wr_cnt0++;
            check("wr_while_busy0", 32'(tx_busy0), 0);
            if (q.size() == 0) check("unexpected_wr0", 32'(data_out0), 32'hFFFF_FFFF);
            else begin
                check("frame_byte", 32'(data_out0), 32'(q.pop_front()));
                if (q.size() == 0) check("busy_at_last_wr", 32'(frame_busy0), 1);
            end
        end
        if (wr1) check("wr_while_busy1", 32'(tx_busy1), 0);
    end

    task automatic push_frame(input logic [7:0] bm);
        logic [7:0] s, b;
        s = 8'h00;
        q.push_back(8'hA5);
        b = 8'd3; q.push_back(b); s = s + b;
        b = bm;   q.push_back(b); s = s + b;
        for (int k = 0; k < 3; k++) begin
            b = m_sh[k][15:8]; q.push_back(b); s = s + b;
            b = m_sh[k][7:0];  q.push_back(b); s = s + b;
        end
        q.push_back(s);
        m_fr = 3'b000;
    endtask

    task automatic load(input logic [2:0] mask, input logic [15:0] d0, d1, d2);
        logic [15:0] d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        @(negedge clk);
        ch_data0 = {d2, d1, d0};
        ch_valid0 = mask;
        for (int k = 0; k < 3; k++) if (mask[k]) m_sh[k] = d[k];
        m_fr = m_fr | mask;
        @(negedge clk);
        ch_valid0 = 3'b000;
    endtask

    task automatic pulse_start();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q.size() != 0 || frame_busy0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("frame_timeout", 32'(q.size()), 0);
    endtask

    typedef struct {
        logic [2:0]  mask;
        logic [15:0] d0, d1, d2;
        logic [7:0]  bm;
    } vec_t;

    // ---------------- instance 1 sequence ----------------
    logic dut1_done = 1'b0;
    initial begin
        int n;
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        rst1 = 1'b1;
        while (cyc < 2500) @(negedge clk);
        check("auto_midframe", 32'(frame_busy1), 1);
        rst1 = 1'b0;
        #1;
        check("rst_wr",       32'(wr1),         0);
        check("rst_data_out", 32'(data_out1),   0);
        check("rst_fbusy",    32'(frame_busy1), 0);
        check("rst_overrun",  32'(overrun1),    0);
        repeat (3) @(negedge clk);
        rst1 = 1'b1;
        n = 0;
        while (n < 1500) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (frame_busy1) break;
        end
        check("auto_first_frame_cycles", 32'(n), 1000);
        dut1_done = 1'b1;
    end

    // ---------------- instance 0 sequence ----------------
    initial begin
        vec_t vecs[5];
        int   base, guard;
        vecs[0] = '{3'b111, 16'h0191, 16'hFF5E, 16'h07D0, 8'h07};
        vecs[1] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 8'h00};
        vecs[2] = '{3'b010, 16'h0000, 16'h1234, 16'h0000, 8'h02};
        vecs[3] = '{3'b101, 16'h0000, 16'h0000, 16'hFFFF, 8'h05};
        vecs[4] = '{3'b001, 16'h8000, 16'h0000, 16'h0000, 8'h01};
        for (int k = 0; k < 3; k++) m_sh[k] = 16'h0000;
        m_fr = 3'b000;
        rst0 = 1'b0; start0 = 1'b0; ch_valid0 = '0; ch_data0 = '0;
        @(negedge clk);
        check("reset_wr",       32'(wr0),         0);
        check("reset_data_out", 32'(data_out0),   0);
        check("reset_fbusy",    32'(frame_busy0), 0);
        check("reset_overrun",  32'(overrun0),    0);
        rst0 = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].mask != 3'b000) load(vecs[i].mask, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            base = wr_cnt0;
            pulse_start();
            push_frame(vecs[i].bm);
            wait_done();
            check("wr_pulses_per_frame", 32'(wr_cnt0 - base), 10);
        end

        // one trigger queues, the next one is dropped
        pulse_start();
        push_frame(m_fr);
        repeat (20) @(negedge clk);
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        push_frame(m_fr);
        repeat (20) @(negedge clk);
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        wait_done();
        check("overrun_cnt", 32'(overrun0), 1);

        // ch_valid coinciding with SNAP
        load(3'b010, m_sh[0], 16'hABCD, m_sh[2]);
        pulse_start();
        push_frame(m_fr);
        ch_data0[31:16] = 16'h1234;
        ch_valid0 = 3'b010;
        @(negedge clk);
        ch_valid0 = 3'b000;
        m_sh[1] = 16'h1234;
        m_fr = 3'b010;
        wait_done();
        pulse_start();
        push_frame(m_fr);
        wait_done();

        // long UART stall after byte 3
        load(3'b100, m_sh[0], m_sh[1], 16'h0FA0);
        base = wr_cnt0;
        pulse_start();
        push_frame(m_fr);
        guard = 0;
        while (wr_cnt0 < base + 3 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        hold0 = 1'b1;
        base = wr_cnt0;
        repeat (500) @(negedge clk);
        check("no_wr_during_stall", 32'(wr_cnt0 - base), 0);
        hold0 = 1'b0;
        wait_done();

        guard = 0;
        while (!dut1_done && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        if (!dut1_done) check("auto_seq_timeout", 32'(dut1_done), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
